voxel_dispatcher: RTL and testbench
===================================

Name: voxel_dispatcher

Overview:
Initiator side of the shader-array broadcast bus.
- Fetches a voxel list from voxel memory and broadcasts one voxel at a time (valid + coordinates + palette id) to all pixel shaders.
- After each broadcast, waits until every shader reports rasterizing_done.
- After the last voxel, waits for all shading_done, then scans row/col to read each shader's tri-stated pixel into the framebuffer writer.
- Sits between the command/register block and the ROWS x COLS shader array.

Parameters:
ROWS, 4, shader array rows
COLS, 4, shader array columns
ROW_BITS, 8, width of row select
COL_BITS, 8, width of col select
COORD_BITS, 8, voxel coordinate width
PALETTE_BITS, 8, voxel id width
PIXEL_BITS, 8, pixel width
ADDR_BITS, 16, voxel memory / count width
FB_ADDR_BITS, 16, framebuffer address width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  begin a frame (sampled only in IDLE)
voxel_count  in  ADDR_BITS  number of voxels; latched on accepted start
vmem_rd  out  1  voxel memory read strobe
vmem_addr  out  ADDR_BITS  voxel memory address
vmem_rdata  in  3*COORD_BITS+PALETTE_BITS  {x,y,z,id}, x in MSBs; valid 1 cycle after vmem_rd
valid  out  1  broadcast strobe to all shaders
voxel_x  out  COORD_BITS  broadcast x
voxel_y  out  COORD_BITS  broadcast y
voxel_z  out  COORD_BITS  broadcast z
voxel_id  out  PALETTE_BITS  broadcast palette id
rasterizing_done  in  ROWS*COLS  per-shader rasterize done
shading_done  in  ROWS*COLS  per-shader shade done
row  out  ROW_BITS  readout row select
col  out  COL_BITS  readout col select
pixel  in  PIXEL_BITS  shared tri-state pixel bus
fb_we  out  1  framebuffer write strobe
fb_addr  out  FB_ADDR_BITS  row*COLS+col
fb_data  out  PIXEL_BITS  pixel value
fb_ready  in  1  framebuffer accepts write this cycle
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset values (reset low, async): state IDLE; all outputs 0, including valid, vmem_rd, fb_we, busy, done, row, col, voxel_* and address counters.
- IDLE:
  - On start=1: latch voxel_count and clear index.
  - Count 0 goes to WAIT_SHADE; otherwise go to FETCH.
- FETCH: vmem_rd=1, vmem_addr=index, one cycle -> WAIT_DATA.
- WAIT_DATA: capture vmem_rdata into the voxel_* registers -> BROADCAST.
- BROADCAST:
  - valid=1 for exactly one cycle with the registered voxel_* stable.
  - voxel_* hold until the next capture.
  - -> WAIT_RAST.
- WAIT_RAST:
  - Ignore rasterizing_done for the first cycle (shaders clear their flag).
  - Afterwards, once &rasterizing_done=1: increment index; if index==count go to WAIT_SHADE, else go to FETCH.
- Minimum per-voxel period is 5 cycles.
- WAIT_SHADE: when &shading_done=1, set row=0, col=0 -> READOUT.
- READOUT:
  - Each cycle, drive fb_we=1, fb_data=pixel (sampled combinationally from the bus at the current row/col), fb_addr=row*COLS+col.
  - Advance only when fb_ready=1. Otherwise hold row, col and fb_* stable, with fb_we kept high.
  - Scan order is row-major: col wraps at COLS-1 and increments row.
  - After the write at (ROWS-1, COLS-1) is accepted -> FINISH.
- FINISH: done=1 for one cycle; row/col return to 0 -> IDLE.
- start while busy is ignored and not queued.
- voxel_count changes after start are ignored.
- Arithmetic:
  - index is ADDR_BITS and never wraps (bounded by count).
  - fb_addr is computed at FB_ADDR_BITS and truncated.
  - row/col compare against ROWS-1/COLS-1 exactly.
- Reset asserted mid-frame: immediate return to IDLE; valid/fb_we/vmem_rd drop asynchronously; no done pulse.
- Simultaneous last-voxel rasterize completion and shading_done: move to WAIT_SHADE first, then evaluate shading_done the next cycle.

Decomposition:
- Shared package holds:
  - the dispatcher state enum (IDLE, FETCH, WAIT_DATA, BROADCAST, WAIT_RAST, WAIT_SHADE, READOUT, FINISH);
  - a packed voxel_t struct {x,y,z,id} used for both the vmem_rdata unpack and the broadcast registers.
- One sub-module, pixel_scan_counter: row/col counter with enable, wrap, last flag and fb_addr generation.

Test Plan:
- voxel_count=2, memory {1,2,3,7},{4,5,6,9}, rasterizing_done all high 3 cycles after each valid -> exactly two one-cycle valid pulses carrying the x,y,z,id values {1,2,3,7} then {4,5,6,9}; vmem_addr 0 then 1.
- ROWS=COLS=4, voxel_count=1, shader at (r,c) drives pixel=r*4+c, fb_ready=1 -> 16 writes, fb_addr 0..15 in order with fb_data equal to fb_addr, then a single done pulse.
- READOUT with fb_ready low for 3 cycles at (1,2) -> fb_addr=6 and fb_data held for 4 cycles; scan then continues to 7; total 16 accepted writes.
- One shader's rasterizing_done held low for 20 cycles -> no second valid until it rises; busy stays 1.
- voxel_count=0 with start -> no vmem_rd or valid; waits for shading_done, then full readout and done.
- reset pulled low during WAIT_RAST of voxel 3/5 -> outputs 0 immediately; after release, start with count=1 runs cleanly from vmem_addr 0.

Source files
------------

// File: rtl/voxel_dispatcher_pkg.sv
// Shared types for the voxel dispatcher: FSM state encoding and the voxel record.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// voxel_t is sized by the VOX_* localparams below; the top-level COORD_BITS and
// PALETTE_BITS parameters must agree with them so the vmem word unpacks cleanly.
package voxel_dispatcher_pkg;

  localparam int VOX_COORD_BITS   = 8;
  localparam int VOX_PALETTE_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    BROADCAST,
    WAIT_RAST,
    WAIT_SHADE,
    READOUT,
    FINISH
  } disp_state_t;

  // x occupies the MSBs, matching the voxel memory word layout.
  typedef struct packed {
    logic [VOX_COORD_BITS-1:0]   x;
    logic [VOX_COORD_BITS-1:0]   y;
    logic [VOX_COORD_BITS-1:0]   z;
    logic [VOX_PALETTE_BITS-1:0] id;
  } voxel_t;

endpackage

// File: rtl/voxel_dispatcher_scan.sv
// Row-major row/col scan counter for shader readout, with framebuffer address.
// Latency: row/col registered; fb_addr and last are combinational from row/col.
// Backpressure: advances only while enable is high; clear has priority.
//
// Ports: clock, reset (async active-low), clear, enable -> row, col, last, fb_addr.
module pixel_scan_counter #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int ROW_BITS     = 8,
  parameter int COL_BITS     = 8,
  parameter int FB_ADDR_BITS = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    enable,
  output logic [ROW_BITS-1:0]     row,
  output logic [COL_BITS-1:0]     col,
  output logic                    last,
  output logic [FB_ADDR_BITS-1:0] fb_addr
);

  logic row_end;
  logic col_end;

  assign row_end = (row == ROW_BITS'(ROWS - 1));
  assign col_end = (col == COL_BITS'(COLS - 1));
  assign last    = row_end && col_end;

  // Computed at framebuffer width; anything beyond it is intentionally dropped.
  assign fb_addr = FB_ADDR_BITS'(row) * FB_ADDR_BITS'(COLS) + FB_ADDR_BITS'(col);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (enable) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + ROW_BITS'(1);
      end else begin
        col <= col + COL_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/voxel_dispatcher.sv
// Fetches voxels, broadcasts each to the shader array, then scans pixels to the framebuffer.
// Latency: 5 cycles minimum per voxel (fetch, data, broadcast, 2+ rasterize wait).
// Backpressure: stalls on rasterizing_done/shading_done; readout holds fb_* while fb_ready is low.
//
// Ports: start/voxel_count command; vmem_rd/vmem_addr/vmem_rdata voxel memory;
// valid/voxel_* broadcast; rasterizing_done/shading_done shader status;
// row/col/pixel readout bus; fb_we/fb_addr/fb_data/fb_ready framebuffer; busy/done status.
module voxel_dispatcher
  import voxel_dispatcher_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int ROW_BITS     = 8,
  parameter int COL_BITS     = 8,
  parameter int COORD_BITS   = 8,
  parameter int PALETTE_BITS = 8,
  parameter int PIXEL_BITS   = 8,
  parameter int ADDR_BITS    = 16,
  parameter int FB_ADDR_BITS = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic [ADDR_BITS-1:0]               voxel_count,
  output logic                               vmem_rd,
  output logic [ADDR_BITS-1:0]               vmem_addr,
  input  logic [3*COORD_BITS+PALETTE_BITS-1:0] vmem_rdata,
  output logic                               valid,
  output logic [COORD_BITS-1:0]              voxel_x,
  output logic [COORD_BITS-1:0]              voxel_y,
  output logic [COORD_BITS-1:0]              voxel_z,
  output logic [PALETTE_BITS-1:0]            voxel_id,
  input  logic [ROWS*COLS-1:0]               rasterizing_done,
  input  logic [ROWS*COLS-1:0]               shading_done,
  output logic [ROW_BITS-1:0]                row,
  output logic [COL_BITS-1:0]                col,
  input  logic [PIXEL_BITS-1:0]              pixel,
  output logic                               fb_we,
  output logic [FB_ADDR_BITS-1:0]            fb_addr,
  output logic [PIXEL_BITS-1:0]              fb_data,
  input  logic                               fb_ready,
  output logic                               busy,
  output logic                               done
);

  disp_state_t          state;
  logic [ADDR_BITS-1:0] count_q;
  logic [ADDR_BITS-1:0] index;
  logic [ADDR_BITS-1:0] index_inc;
  logic                 rast_armed;
  voxel_t               vox_q;
  voxel_t               rdata_v;
  logic                 scan_en;
  logic                 scan_clr;
  logic                 scan_last;

  assign rdata_v   = voxel_t'(vmem_rdata);
  assign index_inc = index + ADDR_BITS'(1);

  assign voxel_x  = vox_q.x;
  assign voxel_y  = vox_q.y;
  assign voxel_z  = vox_q.z;
  assign voxel_id = vox_q.id;

  // The pixel bus is only meaningful while we are writing; keep fb_data quiet otherwise.
  assign fb_data = fb_we ? pixel : '0;

  // Counter sits at (0,0) outside READOUT, so it is already cleared on entry
  // and returns to 0 as soon as the scan finishes.
  assign scan_en  = (state == READOUT) && fb_ready;
  assign scan_clr = (state != READOUT);

  pixel_scan_counter #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .ROW_BITS     (ROW_BITS),
    .COL_BITS     (COL_BITS),
    .FB_ADDR_BITS (FB_ADDR_BITS)
  ) u_scan (
    .clock   (clock),
    .reset   (reset),
    .clear   (scan_clr),
    .enable  (scan_en),
    .row     (row),
    .col     (col),
    .last    (scan_last),
    .fb_addr (fb_addr)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count_q    <= '0;
      index      <= '0;
      rast_armed <= 1'b0;
      vox_q      <= '0;
      vmem_rd    <= 1'b0;
      vmem_addr  <= '0;
      valid      <= 1'b0;
      fb_we      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Single-cycle strobes default low.
      vmem_rd <= 1'b0;
      valid   <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count_q <= voxel_count;
            index   <= '0;
            busy    <= 1'b1;
            if (voxel_count == '0) begin
              state <= WAIT_SHADE;
            end else begin
              state     <= FETCH;
              vmem_rd   <= 1'b1;
              vmem_addr <= '0;
            end
          end
        end
        FETCH: state <= WAIT_DATA;
        WAIT_DATA: begin
          vox_q <= rdata_v;
          valid <= 1'b1;
          state <= BROADCAST;
        end
        BROADCAST: begin
          rast_armed <= 1'b0;
          state      <= WAIT_RAST;
        end
        WAIT_RAST: begin
          // Shaders need one cycle to drop their previous done flag.
          if (!rast_armed) begin
            rast_armed <= 1'b1;
          end else if (&rasterizing_done) begin
            index <= index_inc;
            if (index_inc == count_q) begin
              state <= WAIT_SHADE;
            end else begin
              state     <= FETCH;
              vmem_rd   <= 1'b1;
              vmem_addr <= index_inc;
            end
          end
        end
        WAIT_SHADE: begin
          if (&shading_done) begin
            state <= READOUT;
            fb_we <= 1'b1;
          end
        end
        READOUT: begin
          if (fb_ready && scan_last) begin
            fb_we <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voxel_dispatcher.sv
// Self-checking bench for voxel_dispatcher: randomized frames against a queue-based model.
// Latency: n/a.
// Backpressure: bench drives fb_ready stalls and slow shaders.
module tb_voxel_dispatcher;
  import voxel_dispatcher_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int NPIX = ROWS * COLS;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] voxel_count = '0;
  logic        vmem_rd;
  logic [15:0] vmem_addr;
  logic [31:0] vmem_rdata = '0;
  logic        valid;
  logic [7:0]  voxel_x, voxel_y, voxel_z, voxel_id;
  logic [15:0] rasterizing_done;
  logic [15:0] shading_done;
  logic [7:0]  row, col;
  wire  [7:0]  pixel;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_ready;
  logic        busy, done;

  voxel_dispatcher dut (
    .clock(clock), .reset(reset), .start(start), .voxel_count(voxel_count),
    .vmem_rd(vmem_rd), .vmem_addr(vmem_addr), .vmem_rdata(vmem_rdata),
    .valid(valid), .voxel_x(voxel_x), .voxel_y(voxel_y), .voxel_z(voxel_z),
    .voxel_id(voxel_id), .rasterizing_done(rasterizing_done),
    .shading_done(shading_done), .row(row), .col(col), .pixel(pixel),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Shader at (r,c) drives its pixel onto the shared bus when selected.
  logic [7:0] salt = '0;
  assign pixel = (row < ROWS && col < COLS) ? (8'(row * COLS + col) ^ salt) : 8'hzz;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference memory and scoreboard queues.
  logic [31:0] mem [0:63];
  logic [15:0] q_addr [$];
  logic [31:0] q_vox  [$];
  logic [23:0] q_wr   [$];
  int          q_done = 0;

  // Shader/framebuffer environment knobs.
  int frame_n = 0, seen = 0, rlo = 1, rhi = 3;
  int force_idx = -1, force_delay = 0, shade_delay = 0, shade_cnt = 0;
  int rt [NPIX];
  int stall_addr = -1, stall_left = 0;
  bit rand_ready = 1'b0;

  // Voxel memory: data appears one cycle after the read strobe; junk otherwise.
  initial begin
    bit          rd_q;
    logic [15:0] addr_q;
    forever begin
      @(negedge clock);
      rd_q   = vmem_rd;
      addr_q = vmem_addr;
      @(posedge clock);
      #1;
      vmem_rdata = rd_q ? mem[addr_q[5:0]] : $urandom;
    end
  end

  // Shader array and framebuffer model.
  initial begin
    rasterizing_done = '1;
    shading_done     = '0;
    fb_ready         = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (valid) begin
        seen++;
        for (int i = 0; i < NPIX; i++) begin
          rt[i] = $urandom_range(rhi, rlo);
          if (i == force_idx && seen == 1) rt[i] = force_delay;
          rasterizing_done[i] = 1'b0;
        end
        shade_cnt = shade_delay;
      end else begin
        for (int i = 0; i < NPIX; i++)
          if (!rasterizing_done[i]) begin
            if (rt[i] <= 1) rasterizing_done[i] = 1'b1;
            else rt[i]--;
          end
      end
      if (seen >= frame_n && &rasterizing_done) begin
        if (shade_cnt == 0) shading_done = '1;
        else begin shade_cnt--; shading_done = '0; end
      end else begin
        shading_done = '0;
      end
      if (stall_left > 0 && fb_we && fb_addr == stall_addr) begin
        fb_ready = 1'b0;
        stall_left--;
      end else begin
        fb_ready = rand_ready ? ($urandom_range(2, 0) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  int cyc = 0, valid_cnt = 0, last_valid_cyc = -1, last_gap = 0;
  int done_cnt = 0, busy_drop = 0, hold6 = 0, wr_cnt = 0;
  bit in_frame = 1'b0, prev_valid = 1'b0, prev_done = 1'b0, prev_stall = 1'b0;
  logic [23:0] prev_wr = '0;

  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        prev_valid = 1'b0; prev_done = 1'b0; prev_stall = 1'b0;
        continue;
      end
      if (vmem_rd) begin
        if (q_addr.size() == 0) chk("vmem_rd_unexpected", 1, 0);
        else chk("vmem_addr", vmem_addr, q_addr.pop_front());
      end
      if (valid) begin
        chk("valid_one_cycle", prev_valid, 0);
        if (q_vox.size() == 0) chk("valid_unexpected", 1, 0);
        else chk("broadcast", {voxel_x, voxel_y, voxel_z, voxel_id}, q_vox.pop_front());
        if (last_valid_cyc >= 0) last_gap = cyc - last_valid_cyc;
        last_valid_cyc = cyc;
        valid_cnt++;
      end
      if (fb_we) begin
        if (prev_stall) chk("fb_hold", {fb_addr, fb_data}, prev_wr);
        if (fb_addr == 16'd6) hold6++;
        if (fb_ready) begin
          wr_cnt++;
          if (q_wr.size() == 0) chk("fb_write_unexpected", 1, 0);
          else chk("fb_write", {fb_addr, fb_data}, q_wr.pop_front());
        end
      end
      prev_stall = fb_we && !fb_ready;
      prev_wr    = {fb_addr, fb_data};
      if (done) begin
        chk("done_one_cycle", prev_done, 0);
        if (q_done == 0) chk("done_unexpected", 1, 0);
        else q_done--;
        done_cnt++;
        in_frame = 1'b0;
      end else if (in_frame && !busy) begin
        busy_drop++;
      end
      prev_valid = valid;
      prev_done  = done;
    end
  end

  // Expected behaviour of one frame: fetch 0..n-1, broadcast mem[0..n-1],
  // write every pixel in row-major order, one done pulse.
  task automatic frame_setup(input int n, input int sdelay, input logic [7:0] s);
    @(negedge clock);
    frame_n = n; seen = 0; shade_delay = sdelay; shade_cnt = sdelay; salt = s;
    for (int i = 0; i < n; i++) begin
      q_addr.push_back(16'(i));
      q_vox.push_back(mem[i]);
    end
    for (int i = 0; i < NPIX; i++) q_wr.push_back({16'(i), 8'(i) ^ s});
    q_done++;
    wr_cnt = 0; hold6 = 0; valid_cnt = 0; busy_drop = 0; last_valid_cyc = -1;
    @(posedge clock); #1;
    start = 1'b1; voxel_count = 16'(n);
    @(posedge clock); #1;
    start = 1'b0; voxel_count = 16'($urandom); in_frame = 1'b1;
  endtask

  task automatic run_frame(input int n, input int sdelay, input logic [7:0] s, input bit mid_start);
    int k;
    int d0;
    d0 = done_cnt;
    frame_setup(n, sdelay, s);
    k = 0;
    while (done_cnt == d0 && k < 4000) begin
      @(posedge clock); #1;
      k++;
      start = (mid_start && k == 7);
    end
    start = 1'b0;
    chk("frame_done", done_cnt - d0, 1);
    repeat (2) @(negedge clock);
    chk("wr_count", wr_cnt, NPIX);
    chk("voxel_count", valid_cnt, n);
    chk("busy_in_frame", busy_drop, 0);
    chk("busy_idle", busy, 0);
    chk("queues_drained", q_addr.size() + q_vox.size() + q_wr.size() + q_done, 0);
  endtask

  initial begin
    int k;
    int d0;
    #1;
    chk("reset_strobes", {valid, vmem_rd, fb_we, busy, done}, 0);
    chk("reset_scan", {row, col, fb_addr, fb_data}, 0);
    chk("reset_voxel", {voxel_x, voxel_y, voxel_z, voxel_id, vmem_addr}, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Two voxels, shaders done 3 cycles after each broadcast.
    mem[0] = {8'd1, 8'd2, 8'd3, 8'd7};
    mem[1] = {8'd4, 8'd5, 8'd6, 8'd9};
    rlo = 3; rhi = 3;
    run_frame(2, 1, 8'h00, 1'b0);

    // Single voxel, pixel equals scan index.
    rlo = 1; rhi = 3;
    run_frame(1, 0, 8'h00, 1'b0);

    // Framebuffer stall at (1,2).
    stall_addr = 6; stall_left = 3;
    run_frame(1, 2, 8'h00, 1'b0);
    chk("stall_hold_cycles", hold6, 4);
    stall_addr = -1;

    // One slow shader holds off the second broadcast.
    mem[0] = $urandom; mem[1] = $urandom;
    force_idx = 5; force_delay = 20;
    run_frame(2, 1, 8'h3c, 1'b0);
    chk("slow_shader_gap", last_gap, 23);
    force_idx = -1;

    // Empty voxel list.
    run_frame(0, 4, 8'h5a, 1'b0);

    // Random frames with backpressure, stray start and voxel_count churn.
    rand_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 8; i++) mem[i] = $urandom;
      rlo = 1; rhi = $urandom_range(5, 1);
      run_frame($urandom_range(6, 1), $urandom_range(3, 0), 8'($urandom), 1'b1);
    end
    rand_ready = 1'b0;

    // Reset while waiting on voxel 3 of 5.
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    rlo = 8; rhi = 8;
    frame_setup(5, 1, 8'h11);
    k = 0;
    while (valid_cnt < 3 && k < 2000) begin
      @(negedge clock);
      k++;
    end
    chk("reached_voxel3", valid_cnt, 3);
    @(posedge clock); #3;
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    chk("midrst_strobes", {valid, vmem_rd, fb_we, busy, done}, 0);
    chk("midrst_voxel", {voxel_x, voxel_y, voxel_z, voxel_id}, 0);
    chk("midrst_addr", {vmem_addr, row, col}, 0);
    q_addr.delete(); q_vox.delete(); q_wr.delete(); q_done = 0; in_frame = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    chk("midrst_no_done", done_cnt - d0, 0);
    rlo = 1; rhi = 3;
    mem[0] = $urandom;
    run_frame(1, 1, 8'h77, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
